// File: rtl/vec_normalize.sv
// vec_normalize: scales 3-D vectors to unit length using the external
// fixed-latency inv_sqrt pipeline. Vectors wait in an aligned delay line,
// are multiplied by 1/|v| in one register stage, and queue in an output FIFO.
// Upstream flow is credit-controlled because inv_sqrt cannot stall.
module vec_normalize #(
   parameter int W          = 24,
   parameter int INV_LAT    = 11,
   parameter int SHIFT      = 23,
   parameter int FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   input  logic [W-1:0] in_z,
   output logic [W-1:0] isq_x,
   output logic [W-1:0] isq_y,
   output logic [W-1:0] isq_z,
   input  logic [W-1:0] isq_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_x,
   output logic [W-1:0] out_y,
   output logic [W-1:0] out_z,
   output logic         out_zero
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH + 1);
   localparam int DW = 3 * W + 1;   // {zero, x, y, z}

   localparam logic signed [2*W:0] RND  = (2*W+1)'(1) << (SHIFT - 1);
   localparam logic signed [2*W:0] MAXV = (2*W+1)'((1 << (W - 1)) - 1);
   localparam logic signed [2*W:0] MINV = ~MAXV;

   // comp * 1Q23 scale, rounded half-up, then clamped to the W-bit signed range
   function automatic logic [W-1:0] scale(input logic [W-1:0] c, input logic [W-1:0] s);
      logic signed [2*W:0] a;
      logic signed [2*W:0] b;
      logic signed [2*W:0] prod;
      a    = {{(W+1){c[W-1]}}, c};
      b    = {{(W+1){1'b0}}, s};
      prod = (a * b + RND) >>> SHIFT;
      if (prod > MAXV) prod = MAXV;
      if (prod < MINV) prod = MINV;
      return prod[W-1:0];
   endfunction

   logic          accept;
   logic          pop;
   logic [PW-1:0] pending;

   logic          dl_valid [INV_LAT];
   logic [DW-1:0] dl_data  [INV_LAT];
   logic [DW-1:0] last_data;

   logic          mul_valid;
   logic [DW-1:0] mul_data;

   logic [DW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   mem_count;
   logic          head_valid;
   logic [DW-1:0] head_data;
   logic          load_head;

   assign in_ready = (pending < PW'(FIFO_DEPTH));
   assign accept   = in_valid && in_ready;
   assign pop      = head_valid && out_ready;
   assign isq_x    = in_x;
   assign isq_y    = in_y;
   assign isq_z    = in_z;

   assign last_data = dl_data[INV_LAT-1];
   // the head register refills whenever it is empty or being consumed
   assign load_head = (mem_count != '0) && (!head_valid || pop);

   assign out_valid = head_valid;
   assign {out_zero, out_x, out_y, out_z} = head_data;

   // Credit counter: vectors anywhere between acceptance and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   pending <= pending + PW'(1);
            2'b01:   pending <= pending - PW'(1);
            default: pending <= pending;
         endcase
      end
   end

   // Delay line keeps each vector aligned with its inv_sqrt result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < INV_LAT; i++) begin
            dl_valid[i] <= 1'b0;
            dl_data[i]  <= '0;
         end
      end else begin
         dl_valid[0] <= accept;
         dl_data[0]  <= {(in_x == '0) && (in_y == '0) && (in_z == '0), in_x, in_y, in_z};
         for (int i = 1; i < INV_LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_data[i]  <= dl_data[i-1];
         end
      end
   end

   // Multiply stage; a zero vector bypasses the undefined inv_sqrt value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_valid <= 1'b0;
         mul_data  <= '0;
      end else begin
         mul_valid <= dl_valid[INV_LAT-1];
         if (last_data[DW-1]) begin
            mul_data <= {1'b1, {(3*W){1'b0}}};
         end else begin
            mul_data <= {1'b0,
                         scale(last_data[3*W-1:2*W], isq_out),
                         scale(last_data[2*W-1:W],   isq_out),
                         scale(last_data[W-1:0],     isq_out)};
         end
      end
   end

   // FIFO storage array, no reset so it can map to block RAM
   always_ff @(posedge clk) begin
      if (mul_valid) mem[wr_ptr] <= mul_data;
   end

   // FIFO pointers, occupancy and registered head (first-word-fall-through)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_count  <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         if (mul_valid) wr_ptr <= wr_ptr + AW'(1);
         if (load_head) begin
            rd_ptr     <= rd_ptr + AW'(1);
            head_data  <= mem[rd_ptr];
            head_valid <= 1'b1;
         end else if (pop) begin
            head_valid <= 1'b0;
         end
         case ({mul_valid, load_head})
            2'b10:   mem_count <= mem_count + (AW+1)'(1);
            2'b01:   mem_count <= mem_count - (AW+1)'(1);
            default: mem_count <= mem_count;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_normalize.sv
// Self-checking bench for vec_normalize: directed table, backpressure,
// streaming, random handshake and mid-flight reset, all watched by a
// scoreboard that knows the arithmetic, latency and credit rules.
module tb_vec_normalize;

   localparam int W       = 24;
   localparam int INV_LAT = 11;
   localparam int SHIFT   = 23;
   localparam int FD      = 16;
   localparam int LAT     = INV_LAT + 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_x, in_y, in_z;
   logic [W-1:0] isq_x, isq_y, isq_z;
   logic [W-1:0] isq_out;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_x, out_y, out_z;
   logic         out_zero;

   vec_normalize #(.W(W), .INV_LAT(INV_LAT), .SHIFT(SHIFT), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .isq_x(isq_x), .isq_y(isq_y), .isq_z(isq_z),
      .isq_out(isq_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_out    = 0;
   int last_pop = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- inv_sqrt stub: fixed-latency, no reset ----------------
   bit           stub_fixed_en;
   logic [W-1:0] stub_fixed;
   logic [W-1:0] stub_pipe [INV_LAT];

   function automatic logic [W-1:0] stub_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] z);
      if (stub_fixed_en) return stub_fixed;
      return (x ^ {y[11:0], y[23:12]} ^ {z[5:0], z[23:6]}) + 24'h3C5A11;
   endfunction

   always @(posedge clk) begin
      for (int i = INV_LAT - 1; i > 0; i--) stub_pipe[i] <= stub_pipe[i-1];
      stub_pipe[0] <= stub_fn(isq_x, isq_y, isq_z);
   end
   assign isq_out = stub_pipe[INV_LAT-1];

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_scale(input logic [W-1:0] c, input logic [W-1:0] s);
      longint cv, sv, p;
      cv = longint'($signed(c));
      sv = longint'(s);
      p  = (cv * sv + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (p > (longint'(1) <<< (W - 1)) - 1) p = (longint'(1) <<< (W - 1)) - 1;
      if (p < -(longint'(1) <<< (W - 1)))    p = -(longint'(1) <<< (W - 1));
      return W'(p);
   endfunction

   typedef struct {
      logic [W-1:0] x, y, z;
      logic         zero;
      int           acc;
   } exp_t;
   exp_t q[$];

   // Scoreboard: sampled on the falling edge, predicts the next rising edge
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      int   ev;
      if (!rst_n) begin
         q.delete();
         last_pop = 0;
         check("reset_outputs", {out_valid, out_zero, out_x, out_y, out_z}, '0);
      end else begin
         check("in_ready_credit", in_ready, q.size() < FD);
         if (q.size() == 0) begin
            check("out_valid_idle", out_valid, 1'b0);
         end else begin
            ev = (q[0].acc + LAT > last_pop) ? q[0].acc + LAT : last_pop;
            check("out_valid_timing", out_valid, cyc >= ev);
            if (out_valid)
               check("out_data", {out_zero, out_x, out_y, out_z},
                     {q[0].zero, q[0].x, q[0].y, q[0].z});
         end
         if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            last_pop = cyc + 1;
            n_out++;
         end
         if (in_valid && in_ready) begin
            logic [W-1:0] s;
            s      = stub_fn(in_x, in_y, in_z);
            e.zero = (in_x == '0) && (in_y == '0) && (in_z == '0);
            e.x    = e.zero ? '0 : ref_scale(in_x, s);
            e.y    = e.zero ? '0 : ref_scale(in_y, s);
            e.z    = e.zero ? '0 : ref_scale(in_z, s);
            e.acc  = cyc + 1;
            q.push_back(e);
            n_acc++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z);
      in_valid = v;
      in_x = x;
      in_y = y;
      in_z = z;
   endtask

   function automatic logic [W-1:0] rand_comp();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return W'(int'($urandom_range(0, 200)) - 100);
         default: return W'($urandom);
      endcase
   endfunction

   // send one vector and measure cycles until it reaches the head
   task automatic one_shot(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] z, output int k);
      @(posedge clk); #1;
      drive(1'b1, x, y, z);
      @(posedge clk); #1;
      drive(1'b0, '0, '0, '0);
      k = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         k++;
         if (k > 60) break;
      end
   endtask

   typedef struct {
      logic [W-1:0] x, y, z, isq;
      logic [W-1:0] ex, ey, ez;
      logic         ezero;
   } vec_t;
   vec_t tv[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, a0, o0, drops, seen;

      tv[0] = '{W'(1000),   W'(-2000), W'(0),       24'h400000, W'(500), W'(-1000), W'(0), 1'b0};
      tv[1] = '{W'(-3),     W'(3),     24'h7FFFFF,  24'hC00000, W'(-4),  W'(5), 24'h7FFFFF, 1'b0};
      tv[2] = '{W'(-3),     W'(0),     W'(0),       24'h400000, W'(-1),  W'(0), W'(0), 1'b0};
      tv[3] = '{W'(0),      W'(0),     W'(0),       24'hFFFFFF, W'(0),   W'(0), W'(0), 1'b1};
      tv[4] = '{24'h800000, W'(5),     W'(-7),      24'hC00000, 24'h800000, W'(8), W'(-10), 1'b0};
      tv[5] = '{W'(100),    W'(-1),    W'(1),       24'h000001, W'(0),   W'(0), W'(0), 1'b0};

      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0);
      out_ready     = 1'b1;
      stub_fixed_en = 1'b1;
      stub_fixed    = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);

      // directed table: arithmetic, rounding, saturation, zero vector, latency
      for (int i = 0; i < 6; i++) begin
         stub_fixed = tv[i].isq;
         one_shot(tv[i].x, tv[i].y, tv[i].z, k);
         check($sformatf("table%0d_latency", i), k, LAT);
         check($sformatf("table%0d_result", i), {out_zero, out_x, out_y, out_z},
               {tv[i].ezero, tv[i].ex, tv[i].ey, tv[i].ez});
         repeat (2) @(posedge clk);
      end

      // backpressure: 20 offered, 16 credits
      stub_fixed = 24'h800000;
      @(posedge clk); #1;
      out_ready = 1'b0;
      a0 = n_acc;
      o0 = n_out;
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, W'(i), '0, '0);
         @(posedge clk); #1;
      end
      drive(1'b0, '0, '0, '0);
      check("bp_accepted", n_acc - a0, 16);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_head", {out_valid, out_x}, {1'b1, W'(1)});
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_before_pop", in_ready, 1'b0);
      @(negedge clk);
      check("bp_ready_after_pop", in_ready, 1'b1);
      repeat (20) @(negedge clk);
      check("bp_drained", n_out - o0, 16);

      // streaming: 100 back-to-back vectors, hashed inv_sqrt values
      stub_fixed_en = 1'b0;
      a0 = n_acc;
      o0 = n_out;
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 9) == 0) drive(1'b1, '0, '0, '0);
         else drive(1'b1, rand_comp(), rand_comp(), rand_comp());
         @(negedge clk);
         if (!in_ready) drops++;
      end
      @(posedge clk); #1;
      drive(1'b0, '0, '0, '0);
      repeat (LAT + 5) @(posedge clk);
      check("stream_no_drop", drops, 0);
      check("stream_accepted", n_acc - a0, 100);
      check("stream_outputs", n_out - o0, 100);

      // random handshake on both sides
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         drive(1'($urandom_range(0, 1)), rand_comp(), rand_comp(), rand_comp());
         out_ready = ($urandom_range(0, 9) < 7);
      end
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      repeat (LAT + FD + 5) @(posedge clk);
      @(negedge clk);
      check("random_all_delivered", q.size(), 0);

      // reset while five vectors are in flight
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive(1'b1, rand_comp(), W'(i + 1), rand_comp());
      end
      @(posedge clk); #1;
      drive(1'b0, '0, '0, '0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_stale", seen, 0);
      stub_fixed_en = 1'b1;
      stub_fixed    = 24'h400000;
      one_shot(W'(1000), W'(-2000), W'(0), k);
      check("midrst_latency", k, LAT);
      check("midrst_result", {out_zero, out_x, out_y, out_z},
            {1'b0, W'(500), W'(-1000), W'(0)});
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
